// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port switch.
package switch_pkg;

    localparam int NPORTS_DEF = 4;

    // Input-port FSM states, consumed by the port controllers.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROUTE    = 3'd1,
        ARB_WAIT = 3'd2,
        XMIT     = 3'd3,
        POP      = 3'd4
    } state;

    // Packet type carried in the header.
    typedef enum logic [1:0] {
        P_DATA = 2'd0,
        P_CTRL = 2'd1,
        P_MGMT = 2'd2,
        P_RSVD = 2'd3
    } p_type;

    // Output arbiter FSM states.
    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_GRANT   = 2'd1,
        A_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// Rotating-priority picker: first set request bit at or above i_rr_ptr,
// wrapping from NPORTS-1 back to 0.
import switch_pkg::*;

module rr_pick #(
    parameter int NPORTS = NPORTS_DEF,
    parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PW-1:0]     i_rr_ptr,
    output logic              o_found,
    output logic [PW-1:0]     o_idx
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int          w_pos;
        logic [PW-1:0] w_pos_idx;
        o_found   = |i_req;
        o_idx     = '0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            w_pos = int'(i_rr_ptr) + k;
            if (w_pos >= NPORTS) begin
                w_pos = w_pos - NPORTS;
            end
            w_pos_idx = PW'(w_pos);
            if (i_req[w_pos_idx]) begin
                o_idx = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output round-robin arbiter. Grants one input port at a time and holds
// the grant until the winner finishes, withdraws its request, or the hold
// budget runs out. A one-cycle bubble follows every release.
import switch_pkg::*;

module output_arbiter #(
    parameter int NPORTS   = NPORTS_DEF,
    parameter int HOLD_MAX = 16,
    parameter int PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] i_req,
    input  logic [NPORTS-1:0] i_done,
    output logic [NPORTS-1:0] o_grant,
    output logic              o_arb_active,
    output logic [PW-1:0]     o_mux_select,
    output logic              o_timeout,
    output logic              o_abort,
    output arb_state_t        o_dbg_state,
    output logic [PW-1:0]     o_dbg_rr_ptr
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    arb_state_t        r_state;
    logic [NPORTS-1:0] r_grant;
    logic              r_arb_active;
    logic [PW-1:0]     r_mux_select;
    logic              r_timeout;
    logic              r_abort;
    logic [PW-1:0]     r_rr_ptr;
    logic [HW-1:0]     r_hold_cnt;

    logic              w_found;
    logic [PW-1:0]     w_pick_idx;
    logic [NPORTS-1:0] w_pick_onehot;
    logic              w_win_done;
    logic              w_win_req;
    logic              w_hold_expired;
    logic [PW-1:0]     w_next_ptr;

    rr_pick #(.NPORTS(NPORTS), .PW(PW)) u_rr_pick (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_idx    (w_pick_idx)
    );

    // While granted, r_mux_select is the winner index; only its done/req bits matter.
    assign w_pick_onehot  = {{(NPORTS-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_win_done     = i_done[r_mux_select];
    assign w_win_req      = i_req[r_mux_select];
    assign w_hold_expired = (r_hold_cnt == HW'(HOLD_MAX));
    assign w_next_ptr     = (r_mux_select == PW'(NPORTS - 1)) ? '0 : r_mux_select + PW'(1);

    // Arbitration FSM, hold counter, round-robin pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= A_IDLE;
            r_grant      <= '0;
            r_arb_active <= 1'b0;
            r_mux_select <= '0;
            r_timeout    <= 1'b0;
            r_abort      <= 1'b0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
            case (r_state)
                A_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_pick_onehot;
                        r_arb_active <= 1'b1;
                        r_mux_select <= w_pick_idx;
                        r_hold_cnt   <= HW'(1);
                        r_state      <= A_GRANT;
                    end
                end
                A_GRANT: begin
                    if (w_win_done || !w_win_req || w_hold_expired) begin
                        // Completion outranks withdrawal, which outranks the timeout.
                        r_grant      <= '0;
                        r_arb_active <= 1'b0;
                        r_mux_select <= '0;
                        r_hold_cnt   <= '0;
                        r_rr_ptr     <= w_next_ptr;
                        r_state      <= A_RELEASE;
                        if (!w_win_done) begin
                            if (!w_win_req) begin
                                r_abort <= 1'b1;
                            end else begin
                                r_timeout <= 1'b1;
                            end
                        end
                    end else if (!w_hold_expired) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                A_RELEASE: begin
                    r_state <= A_IDLE;
                end
                default: begin
                    r_state <= A_IDLE;
                end
            endcase
        end
    end

    assign o_grant      = r_grant;
    assign o_arb_active = r_arb_active;
    assign o_mux_select = r_mux_select;
    assign o_timeout    = r_timeout;
    assign o_abort      = r_abort;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_output_arbiter;
    import switch_pkg::*;

    localparam int NP = 4;
    localparam int HM = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;

    logic [3:0] o_grant;
    logic       o_arb_active;
    logic [1:0] o_mux_select;
    logic       o_timeout;
    logic       o_abort;
    arb_state_t o_dbg_state;
    logic [1:0] o_dbg_rr_ptr;

    always #5 clk = ~clk;

    output_arbiter #(.NPORTS(NP), .HOLD_MAX(HM)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_done       (done),
        .o_grant      (o_grant),
        .o_arb_active (o_arb_active),
        .o_mux_select (o_mux_select),
        .o_timeout    (o_timeout),
        .o_abort      (o_abort),
        .o_dbg_state  (o_dbg_state),
        .o_dbg_rr_ptr (o_dbg_rr_ptr)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    // ---------------- reference model ----------------
    // Tracks the current owner (or -1), cycles it has held the grant, whether a
    // bubble cycle is pending, and where the next search starts.
    int m_owner  = -1;
    int m_held   = 0;
    int m_ptr    = 0;
    bit m_bubble = 1'b0;
    bit m_to     = 1'b0;
    bit m_ab     = 1'b0;

    always @(posedge clk) begin
        bit released;
        released = 1'b0;
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_bubble = 0; m_to = 0; m_ab = 0;
        end else begin
            m_to = 0;
            m_ab = 0;
            if (m_bubble) begin
                m_bubble = 0;
            end else if (m_owner >= 0) begin
                if (done[m_owner]) released = 1;
                else if (!req[m_owner]) begin released = 1; m_ab = 1; end
                else if (m_held == HM) begin released = 1; m_to = 1; end
                else m_held++;
                if (released) begin
                    m_ptr    = (m_owner + 1) % NP;
                    m_owner  = -1;
                    m_held   = 0;
                    m_bubble = 1;
                end
            end else begin
                for (int off = 0; off < NP; off++) begin
                    if (m_owner < 0 && req[(m_ptr + off) % NP]) begin
                        m_owner = (m_ptr + off) % NP;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    // ---------------- invariants every cycle ----------------
    always @(negedge clk) begin
        n_cmp++;
        if (!$onehot0(o_grant)) begin
            n_fail++; $display("FAIL inv_onehot0: grant=%b is not onehot0", o_grant);
        end
        n_cmp++;
        if (o_arb_active !== (|o_grant)) begin
            n_fail++; $display("FAIL inv_active: arb_active=%b want %b", o_arb_active, |o_grant);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; done = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        req = '0; done = '0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req = '0; done = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
        n_cmp++; if (o_arb_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", o_arb_active); end
        n_cmp++; if (o_mux_select !== 2'd0) begin n_fail++; $display("FAIL reset_mux: got %0d want 0", o_mux_select); end
        n_cmp++; if (o_timeout !== 1'b0 || o_abort !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: to=%b ab=%b want 0 0", o_timeout, o_abort); end
        n_cmp++; if (o_dbg_state !== A_IDLE || o_dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_state: st=%0d ptr=%0d want 0 0", o_dbg_state, o_dbg_rr_ptr); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", o_grant); end
        n_cmp++; if (o_mux_select !== 2'd2 || o_arb_active !== 1'b1) begin n_fail++; $display("FAIL single_mux: mux=%0d act=%b want 2 1", o_mux_select, o_arb_active); end
        n_cmp++; if (o_dbg_state !== A_GRANT) begin n_fail++; $display("FAIL single_state: got %0d want A_GRANT", o_dbg_state); end
        done = 4'b0100;
        @(negedge clk);
        done = '0;
        n_cmp++; if (o_grant !== 4'b0000 || o_mux_select !== 2'd0) begin n_fail++; $display("FAIL single_release: grant=%b mux=%0d want 0000 0", o_grant, o_mux_select); end
        n_cmp++; if (o_dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL single_rrptr: got %0d want 3", o_dbg_rr_ptr); end
        n_cmp++; if (o_abort !== 1'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL single_pulses: to=%b ab=%b want 0 0", o_timeout, o_abort); end
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0000 || o_dbg_state !== A_IDLE) begin n_fail++; $display("FAIL single_bubble: grant=%b st=%0d want 0000 A_IDLE", o_grant, o_dbg_state); end
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0100) begin n_fail++; $display("FAIL single_regrant: got %b want 0100", o_grant); end
        settle();
    endtask

    task automatic test_all_requesting();
        int cnt;
        logic [3:0] want;
        do_reset();
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        req = 4'b1111;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            cnt = 0;
            @(negedge clk);
            while (o_grant === 4'b0000 && cnt < 10) begin @(negedge clk); cnt++; end
            n_cmp++;
            if (cnt >= 10) begin
                n_fail++; $display("FAIL all_req_wait: no grant within 10 cycles, want %b", want);
            end else if (o_grant !== want) begin
                n_fail++; $display("FAIL all_req_order: got %b want %b", o_grant, want);
            end
            @(negedge clk);
            done = want;
            @(negedge clk);
            done = '0;
        end
        settle();
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        cnt = 0;
        while (o_grant === 4'b0001 && cnt < 40) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != HM) begin n_fail++; $display("FAIL timeout_hold: held %0d cycles want %0d", cnt, HM); end
        n_cmp++; if (o_timeout !== 1'b1 || o_abort !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: to=%b ab=%b want 1 0", o_timeout, o_abort); end
        @(negedge clk);
        n_cmp++; if (o_timeout !== 1'b0 || o_grant !== 4'b0000) begin n_fail++; $display("FAIL timeout_once: to=%b grant=%b want 0 0000", o_timeout, o_grant); end
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL timeout_regrant: got %b want 0001", o_grant); end
        settle();
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0010 || o_mux_select !== 2'd1) begin n_fail++; $display("FAIL abort_grant: grant=%b mux=%0d want 0010 1", o_grant, o_mux_select); end
        done = 4'b1000;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0010 || o_abort !== 1'b0) begin n_fail++; $display("FAIL abort_ignore_done: grant=%b ab=%b want 0010 0", o_grant, o_abort); end
        done = '0; req = '0;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0000 || o_abort !== 1'b1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: grant=%b ab=%b to=%b want 0000 1 0", o_grant, o_abort, o_timeout); end
        @(negedge clk);
        n_cmp++; if (o_abort !== 1'b0) begin n_fail++; $display("FAIL abort_once: got %b want 0", o_abort); end
        settle();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0100", o_grant); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0000 || o_arb_active !== 1'b0 || o_mux_select !== 2'd0) begin n_fail++; $display("FAIL rstmid_outs: grant=%b act=%b mux=%0d want 0000 0 0", o_grant, o_arb_active, o_mux_select); end
        n_cmp++; if (o_timeout !== 1'b0 || o_abort !== 1'b0 || o_dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: to=%b ab=%b ptr=%0d want 0 0 0", o_timeout, o_abort, o_dbg_rr_ptr); end
        rst = 1'b0; req = 4'b1010;
        @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0010 || o_mux_select !== 2'd1) begin n_fail++; $display("FAIL rstmid_first: grant=%b mux=%0d want 0010 1", o_grant, o_mux_select); end
        settle();
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        repeat (HM - 1) @(negedge clk);
        n_cmp++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL donetmo_held: got %b want 0001", o_grant); end
        done = 4'b0001;
        @(negedge clk);
        done = '0;
        n_cmp++; if (o_grant !== 4'b0000 || o_timeout !== 1'b0 || o_abort !== 1'b0) begin n_fail++; $display("FAIL donetmo_release: grant=%b to=%b ab=%b want 0000 0 0", o_grant, o_timeout, o_abort); end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        int em;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            em = (m_owner >= 0) ? m_owner : 0;
            n_cmp++; if (o_grant !== eg) begin n_fail++; $display("FAIL rnd_grant @%0d: got %b want %b", i, o_grant, eg); end
            n_cmp++; if (o_mux_select !== 2'(em)) begin n_fail++; $display("FAIL rnd_mux @%0d: got %0d want %0d", i, o_mux_select, em); end
            n_cmp++; if (o_timeout !== m_to || o_abort !== m_ab) begin n_fail++; $display("FAIL rnd_pulses @%0d: to=%b ab=%b want %b %b", i, o_timeout, o_abort, m_to, m_ab); end
            n_cmp++; if (o_dbg_rr_ptr !== 2'(m_ptr)) begin n_fail++; $display("FAIL rnd_rrptr @%0d: got %0d want %0d", i, o_dbg_rr_ptr, m_ptr); end
            if (((i / 200) % 2) == 0) begin
                if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
                done = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            end else begin
                if ($urandom_range(0, 39) == 0) req = 4'($urandom_range(0, 15));
                done = ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            end
        end
        settle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_timeout();
        test_abort();
        test_reset_mid_grant();
        test_done_at_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
